ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Stateful PS/2 set-2 keyboard decoder. It sits between the PS/2 serial receiver and the consumer logic, such as the console or the seven-segment display. It consumes raw scan-code bytes and tracks make/break/extended prefixes, shift and caps-lock state, and the currently held key. Decoded ASCII characters are pushed into a parametrised output FIFO with a valid/ready handshake.

## Interface
Parameters:
- FIFO_DEPTH, 8: output FIFO entries; power of two, at least 2.
- CNT_W, 8: width of the distinct-key-press counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clrn  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_code holds a received scan-code byte this cycle.
- in_code  in  8  raw scan-code byte.
- in_ready  out  1  constant 1; one byte is consumed per cycle.
- out_valid  out  1  FIFO not empty.
- out_ascii  out  8  head-of-FIFO ASCII character.
- out_ready  in  1  consumer pops the head when out_valid & out_ready.
- key_held  out  1  a non-modifier key is currently pressed.
- held_code  out  8  scan code of the last pressed non-modifier key.
- press_cnt  out  CNT_W  count of distinct key presses; wraps modulo 2^CNT_W.
- overflow  out  1  sticky: a character was dropped because the FIFO was full.

## Operation
- **Prefix FSM states:** IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (after 0xE0 0xF0). The FSM advances only on in_valid.
  - IDLE: 0xF0 → BRK; 0xE0 → EXT; any other byte is a make event, stay IDLE.
  - BRK: any byte is a break event → IDLE.
  - EXT: 0xF0 → EXT_BRK; any other byte is consumed and discarded → IDLE.
  - EXT_BRK: any byte is discarded → IDLE.
- **Make of 0x12 or 0x59:** sets the left or right shift flag. Break of the same code clears that flag. No character is output.
- **Make of 0x58 (caps):** toggles caps only if caps_held = 0, then sets caps_held. Break clears caps_held, so typematic repeats do not re-toggle.
- **Make of any other code:**
  - press_cnt increments if key_held = 0 or the code differs from held_code, so a typematic repeat does not count.
  - held_code is loaded with the code and key_held is set.
  - If the code is mapped, its ASCII character is pushed into the FIFO. Typematic repeats push again.
- **Break of any other code:** clears key_held if the code equals held_code; otherwise no effect.
- **Character map:**
  - Letters a–z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A map to 0x61–0x7A.
  - Digits 0–9: 45 16 1E 26 25 2E 36 3D 3E 46 map to 0x30–0x39.
  - Space: 0x29 maps to 0x20.
  - Enter: 0x5A maps to 0x0D.
  - Unmapped codes update the held/press-count state but push nothing.
- **Case:** a letter is output as uppercase (ASCII − 0x20) when (shift_l | shift_r) XOR caps. Digits, space and enter are never case-converted.
- **FIFO:**
  - A push when full and not popping the same cycle drops the character and sets overflow. overflow stays set until reset.
  - A simultaneous push and pop when full succeeds.
  - A simultaneous push and pop when empty is impossible, because out_valid is 0.

## Timing
- **Reset (clrn = 0 at a clock edge):**
  - FSM goes to IDLE; FIFO is emptied; shift, caps and caps_held are cleared.
  - Output values: out_valid = 0, out_ascii = 0, key_held = 0, held_code = 0, press_cnt = 0, overflow = 0.
  - A pending prefix is lost.
- **Latency:** a make byte accepted at edge N with the FIFO empty gives out_valid = 1 and a valid out_ascii after edge N (registered, zero extra cycles).
- **Flag updates:** shift and caps changes from byte N apply to a make at byte N+1 or later.
- **Output stability:** out_ascii is stable while out_valid = 1 and out_ready = 0.
- **Status registers:** key_held, held_code and press_cnt update at the same edge that consumes the make or break byte.

## Configuration
- **PS2_DEC_SHIFT_EN defined:** shift and caps tracking and case conversion are as above.
- **PS2_DEC_SHIFT_EN undefined:** no shift or caps state exists and letters are always lowercase. Codes 0x12, 0x59 and 0x58 are treated as unmapped ordinary keys: they update held_code and press_cnt and push nothing.

## Structure
- **Package ps2_pkg** holds:
  - constants SC_BREAK = 0xF0, SC_EXT = 0xE0, SC_LSHIFT = 0x12, SC_RSHIFT = 0x59, SC_CAPS = 0x58;
  - the FSM state enum (IDLE, BRK, EXT, EXT_BRK);
  - a function sc_to_ascii(code) returning {hit, ascii}.
- **Sub-module ascii_fifo:** parameter DEPTH, 8-bit wide, with push/pop/full/empty and synchronous active-low reset.

## Test plan
- **Single make and break:** send 1C, F0, 1C → FIFO holds 0x61; key_held goes 1 then 0; press_cnt = 1.
- **Typematic repeat:** send 1C, 1C, 1C, F0, 1C → three 0x61 pushed; press_cnt = 1.
- **Shift and caps interaction:** send 12, 1C, F0, 12, 58, F0, 58, 1C, 12, 1C → outputs 0x41, 0x41, 0x61 (shift XOR caps).
- **Extended code discard:** send E0, 75, E0, F0, 75 → no push; key_held unchanged; FSM back in IDLE.
- **FIFO overflow:** FIFO_DEPTH = 4, out_ready = 0, send makes 16 1E 26 25 2E → four entries 0x31–0x34, overflow = 1. Raise out_ready → pops in order.
- **Reset mid-prefix:** send F0, pulse clrn low for one cycle, send 1C → output 0x61 (prefix lost); all outputs were 0 during reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, prefix-FSM state type and scan-code lookup for
// the PS/2 set-2 keyboard decoder.
//   SC_*          : special scan-code bytes (prefixes and modifier keys)
//   ps2_state_e   : prefix FSM states
//   sc_to_ascii() : returns {hit, ascii}; hit = 0 for unmapped codes
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

  // Lowercase letters, digits, space and enter; everything else misses.
  function automatic logic [8:0] sc_to_ascii(input logic [7:0] code);
    logic [8:0] r;
    case (code)
      8'h1C: r = {1'b1, 8'h61};  8'h32: r = {1'b1, 8'h62};
      8'h21: r = {1'b1, 8'h63};  8'h23: r = {1'b1, 8'h64};
      8'h24: r = {1'b1, 8'h65};  8'h2B: r = {1'b1, 8'h66};
      8'h34: r = {1'b1, 8'h67};  8'h33: r = {1'b1, 8'h68};
      8'h43: r = {1'b1, 8'h69};  8'h3B: r = {1'b1, 8'h6A};
      8'h42: r = {1'b1, 8'h6B};  8'h4B: r = {1'b1, 8'h6C};
      8'h3A: r = {1'b1, 8'h6D};  8'h31: r = {1'b1, 8'h6E};
      8'h44: r = {1'b1, 8'h6F};  8'h4D: r = {1'b1, 8'h70};
      8'h15: r = {1'b1, 8'h71};  8'h2D: r = {1'b1, 8'h72};
      8'h1B: r = {1'b1, 8'h73};  8'h2C: r = {1'b1, 8'h74};
      8'h3C: r = {1'b1, 8'h75};  8'h2A: r = {1'b1, 8'h76};
      8'h1D: r = {1'b1, 8'h77};  8'h22: r = {1'b1, 8'h78};
      8'h35: r = {1'b1, 8'h79};  8'h1A: r = {1'b1, 8'h7A};
      8'h45: r = {1'b1, 8'h30};  8'h16: r = {1'b1, 8'h31};
      8'h1E: r = {1'b1, 8'h32};  8'h26: r = {1'b1, 8'h33};
      8'h25: r = {1'b1, 8'h34};  8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36};  8'h3D: r = {1'b1, 8'h37};
      8'h3E: r = {1'b1, 8'h38};  8'h46: r = {1'b1, 8'h39};
      8'h29: r = {1'b1, 8'h20};
      8'h5A: r = {1'b1, 8'h0D};
      default: r = {1'b0, 8'h00};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_fifo.sv
// ascii_fifo: DEPTH x 8-bit FIFO, synchronous active-low reset.
//   clk, clrn        : clock, synchronous active-low reset
//   push_i, din_i    : write strobe and data (accepted when not full, or
//                      when full but popping the same cycle)
//   pop_i            : read strobe (ignored when empty)
//   dout_o           : head entry, 0 when empty
//   full_o, empty_o  : status
module ascii_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok_s, pop_ok_s;

  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == {(AW+1){1'b0}});
  assign dout_o  = empty_o ? 8'h00 : mem_q[rd_q];

  // Push and pop qualification plus pointer/count next state.
  always_comb begin
    push_ok_s = push_i & (~full_o | pop_i);
    pop_ok_s  = pop_i & ~empty_o;
    wr_d      = push_ok_s ? (wr_q + PTR_ONE) : wr_q;
    rd_d      = pop_ok_s  ? (rd_q + PTR_ONE) : rd_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_ok_s) mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scan-code decoder with ASCII output FIFO.
// Optional feature macro: PS2_DEC_SHIFT_EN enables shift/caps tracking and
// letter case conversion; without it 0x12/0x59/0x58 are ordinary unmapped keys.
//   clk, clrn            : clock, synchronous active-low reset
//   in_valid, in_code    : raw scan-code byte input; in_ready is always 1
//   out_valid, out_ascii : FIFO head; popped on out_valid & out_ready
//   key_held, held_code  : last pressed non-modifier key and whether it is down
//   press_cnt            : distinct key presses (typematic repeats excluded)
//   overflow             : sticky, a character was dropped on a full FIFO
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  input  logic [7:0]       in_code,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_ascii,
  input  logic             out_ready,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow
);

  ps2_state_e       state_q, state_d;
  logic             key_held_q, key_held_d;
  logic [7:0]       held_code_q, held_code_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             overflow_q, overflow_d;
  logic             make_s, brk_s, mod_s, upper_s, letter_s;
  logic [8:0]       lookup_s;
  logic             push_s, pop_s, full_s, empty_s;
  logic [7:0]       push_data_s;
`ifdef PS2_DEC_SHIFT_EN
  logic             shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic             caps_q, caps_d, caps_held_q, caps_held_d;
`endif

  assign in_ready  = 1'b1;
  assign out_valid = ~empty_s;
  assign pop_s     = out_valid & out_ready;
  assign key_held  = key_held_q;
  assign held_code = held_code_q;
  assign press_cnt = press_cnt_q;
  assign overflow  = overflow_q;

  // Prefix FSM: classifies each byte as make, break, prefix or discarded.
  always_comb begin
    state_d = state_q;
    make_s  = 1'b0;
    brk_s   = 1'b0;
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in_code == SC_BREAK)    state_d = BRK;
          else if (in_code == SC_EXT) state_d = EXT;
          else                        make_s  = 1'b1;
        end
        BRK: begin
          brk_s   = 1'b1;
          state_d = IDLE;
        end
        EXT: begin
          if (in_code == SC_BREAK) state_d = EXT_BRK;
          else                     state_d = IDLE;
        end
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Key event handling: modifiers, held-key status, press count, FIFO push.
  always_comb begin
    key_held_d  = key_held_q;
    held_code_d = held_code_q;
    press_cnt_d = press_cnt_q;
    push_s      = 1'b0;
    lookup_s    = sc_to_ascii(in_code);
    letter_s    = (lookup_s[7:0] >= 8'h61) && (lookup_s[7:0] <= 8'h7A);
`ifdef PS2_DEC_SHIFT_EN
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    mod_s       = (in_code == SC_LSHIFT) || (in_code == SC_RSHIFT) || (in_code == SC_CAPS);
    upper_s     = (shift_l_q | shift_r_q) ^ caps_q;
    if (make_s) begin
      if (in_code == SC_LSHIFT)      shift_l_d = 1'b1;
      else if (in_code == SC_RSHIFT) shift_r_d = 1'b1;
      else if (in_code == SC_CAPS) begin
        // caps_held blocks re-toggling on typematic repeats of caps.
        if (!caps_held_q) caps_d = ~caps_q;
        else              caps_d = caps_q;
        caps_held_d = 1'b1;
      end else begin
        caps_d = caps_q;
      end
    end else if (brk_s) begin
      if (in_code == SC_LSHIFT)      shift_l_d   = 1'b0;
      else if (in_code == SC_RSHIFT) shift_r_d   = 1'b0;
      else if (in_code == SC_CAPS)   caps_held_d = 1'b0;
      else                           caps_d      = caps_q;
    end else begin
      caps_d = caps_q;
    end
`else
    mod_s   = 1'b0;
    upper_s = 1'b0;
`endif
    push_data_s = (letter_s && upper_s) ? (lookup_s[7:0] - 8'h20) : lookup_s[7:0];
    if (make_s && !mod_s) begin
      // A repeat of the already-held key is typematic, not a new press.
      if (!key_held_q || (in_code != held_code_q)) press_cnt_d = press_cnt_q + CNT_W'(1);
      else                                         press_cnt_d = press_cnt_q;
      held_code_d = in_code;
      key_held_d  = 1'b1;
      push_s      = lookup_s[8];
    end else if (brk_s && !mod_s) begin
      if (in_code == held_code_q) key_held_d = 1'b0;
      else                        key_held_d = key_held_q;
    end else begin
      push_s = 1'b0;
    end
    overflow_d = overflow_q | (push_s & full_s & ~pop_s);
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= IDLE;
      key_held_q  <= 1'b0;
      held_code_q <= 8'h00;
      press_cnt_q <= '0;
      overflow_q  <= 1'b0;
`ifdef PS2_DEC_SHIFT_EN
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      key_held_q  <= key_held_d;
      held_code_q <= held_code_d;
      press_cnt_q <= press_cnt_d;
      overflow_q  <= overflow_d;
`ifdef PS2_DEC_SHIFT_EN
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
`endif
    end
  end

  ascii_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push_i  (push_s),
    .din_i   (push_data_s),
    .pop_i   (pop_s),
    .dout_o  (out_ascii),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder (FIFO_DEPTH = 4). Expected ASCII
// characters are queued when the bytes are sent; a monitor pops and compares
// on every handshake. Status outputs are compared against hand-derived values.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_code = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_ascii;
  logic       out_ready = 1'b1;
  logic       key_held;
  logic [7:0] held_code;
  logic [7:0] press_cnt;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  ps2_key_decoder #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ascii (out_ascii),
    .out_ready (out_ready),
    .key_held  (key_held),
    .held_code (held_code),
    .press_cnt (press_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

`ifdef PS2_DEC_SHIFT_EN
  localparam logic [7:0] EXP_A1 = 8'h41;
  localparam logic [7:0] EXP_A2 = 8'h41;
  localparam int CNT_BASE = 3;
`else
  localparam logic [7:0] EXP_A1 = 8'h61;
  localparam logic [7:0] EXP_A2 = 8'h61;
  localparam int CNT_BASE = 9;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 40) begin
      idle(1);
      k++;
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_out_valid", out_valid, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_ascii"}, out_ascii, 8'h00);
    chk({tag, "_key_held"},  key_held, 1'b0);
    chk({tag, "_held_code"}, held_code, 8'h00);
    chk({tag, "_press_cnt"}, press_cnt, 8'h00);
    chk({tag, "_overflow"},  overflow, 1'b0);
  endtask

  // Monitor: compare the head on every handshake against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", out_ascii, 8'hXX);
        end else begin
          chk("fifo_data", out_ascii, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    idle(3);
    chk_reset_outputs("rst");
    chk("in_ready", in_ready, 1'b1);
    clrn = 1'b1;

    // Single make and break
    send(8'h1C); sb.push_back(8'h61);
    idle(1);
    chk("t1_key_held", key_held, 1'b1);
    chk("t1_held_code", held_code, 8'h1C);
    chk("t1_press_cnt", press_cnt, 8'd1);
    send(8'hF0); send(8'h1C);
    idle(1);
    chk("t1_key_released", key_held, 1'b0);
    chk("t1_press_cnt2", press_cnt, 8'd1);

    // Typematic repeat
    for (int i = 0; i < 3; i++) begin
      send(8'h1C); sb.push_back(8'h61);
    end
    send(8'hF0); send(8'h1C);
    idle(1);
    chk("t2_press_cnt", press_cnt, 8'd2);
    chk("t2_key_held", key_held, 1'b0);

    // Shift and caps interaction
    send(8'h12);
    send(8'h1C); sb.push_back(EXP_A1);
    send(8'hF0); send(8'h12);
    send(8'h58);
    send(8'hF0); send(8'h58);
    send(8'h1C); sb.push_back(EXP_A2);
    send(8'h12);
    send(8'h1C); sb.push_back(8'h61);
    idle(1);
    chk("t3_held_code", held_code, 8'h1C);
    chk("t3_key_held", key_held, 1'b1);
    // Release everything and toggle caps back off.
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    send(8'h58);
    send(8'hF0); send(8'h58);
    idle(1);
    chk("t3_press_cnt", press_cnt, CNT_BASE);
    chk("t3_key_held_rel", key_held, 1'b0);
    drain();

    // Extended code discard
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(2);
    chk("t4_no_push", out_valid, 1'b0);
    chk("t4_key_held", key_held, 1'b0);
    chk("t4_press_cnt", press_cnt, CNT_BASE);
    send(8'h1C); sb.push_back(8'h61);
    idle(1);
    chk("t4_idle_make_cnt", press_cnt, CNT_BASE + 1);
    send(8'hF0); send(8'h1C);
    drain();

    // FIFO overflow, then push+pop while full
    out_ready = 1'b0;
    send(8'h16); sb.push_back(8'h31);
    send(8'h1E); sb.push_back(8'h32);
    send(8'h26); sb.push_back(8'h33);
    send(8'h25); sb.push_back(8'h34);
    send(8'h2E);
    idle(2);
    chk("t5_overflow", overflow, 1'b1);
    chk("t5_out_valid", out_valid, 1'b1);
    chk("t5_head_stable", out_ascii, 8'h31);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 8'h36;
    sb.push_back(8'h36);
    idle(1);
    chk("t5_press_cnt", press_cnt, CNT_BASE + 7);
    send(8'hF0); send(8'h36);
    drain();
    chk("t5_overflow_sticky", overflow, 1'b1);

    // Reset mid-prefix
    send(8'hF0);
    @(negedge clk);
    in_valid = 1'b0;
    clrn     = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6");
    clrn = 1'b1;
    send(8'h1C); sb.push_back(8'h61);
    idle(1);
    chk("t6_press_cnt", press_cnt, 8'd1);
    chk("t6_key_held", key_held, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
